uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 111 +++++++++++
 tb/tb_uart_tx.sv | 104 ++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first serial transmitter fed by a byte FIFO, with a dropped-write pulse.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_flag,
    input  logic [7:0] rx_byte,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic tx_serial_q, tx_serial_d, tx_busy_q, tx_busy_d;
    logic fifo_full_q, fifo_full_d, overflow_q, overflow_d;
    logic [7:0] mem [FIFO_DEPTH];
    logic full, empty, push, pop, bit_end;
    assign full    = count_q == (AW+1)'(FIFO_DEPTH);
    assign empty   = count_q == '0;
    assign push    = rx_flag && !full;
    assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        tx_serial_d = tx_serial_q;
        unique case (state_q)
            IDLE: begin
                cnt_d       = '0;
                tx_serial_d = 1'b1;
            end
            START: if (bit_end) begin
                state_d     = DATA;
                cnt_d       = '0;
                idx_d       = '0;
                tx_serial_d = shift_q[0];
            end
            DATA: if (bit_end) begin
                cnt_d       = '0;
                state_d     = idx_q == 3'd7 ? STOP : DATA;
                idx_d       = idx_q + 3'd1;
                shift_d     = shift_q >> 1;
                tx_serial_d = idx_q == 3'd7 ? 1'b1 : shift_q[1];
            end
            STOP: if (bit_end) begin
                state_d     = IDLE;
                cnt_d       = '0;
                tx_serial_d = 1'b1;
            end
        endcase
        // A pending byte launches its start bit from IDLE or straight out of the stop bit
        pop = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
        if (pop) begin
            state_d     = START;
            cnt_d       = '0;
            shift_d     = mem[rd_ptr_q];
            tx_serial_d = 1'b0;
        end
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
        tx_busy_d   = state_d != IDLE || count_d != '0;
        fifo_full_d = count_d == (AW+1)'(FIFO_DEPTH);
        overflow_d  = rx_flag && full;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_serial_q <= 1'b1;
            tx_busy_q   <= 1'b0;
            fifo_full_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_serial_q <= tx_serial_d;
            tx_busy_q   <= tx_busy_d;
            fifo_full_q <= fifo_full_d;
            overflow_q  <= overflow_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr_q] <= rx_byte;
    end
    assign tx_serial = tx_serial_q;
    assign tx_busy   = tx_busy_q;
    assign fifo_full = fifo_full_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives uart_tx with directed and random writes against a frame-level line model.
module tb_uart_tx;
    localparam int C = 16;
    localparam int D = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_flag = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic tx_serial, tx_busy, fifo_full, overflow;
    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];
    int rem = 0;
    logic [7:0] cur = 8'h00;
    logic exp_ovf = 1'b0;
    int ovf_cnt = 0;

    uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .rx_flag(rx_flag), .rx_byte(rx_byte),
        .tx_serial(tx_serial), .tx_busy(tx_busy), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Frame slot p (0=start, 1..8 data LSB first, 9=stop) derived from cycles elapsed in the frame
    function automatic logic line_exp();
        int p;
        if (rem == 0) return 1'b1;
        p = (10 * C - rem) / C;
        return p == 0 ? 1'b0 : p == 9 ? 1'b1 : cur[p-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic [7:0] b);
        rst_n = r;
        rx_flag = f;
        rx_byte = b;
        @(posedge clk);
        if (!r) begin
            q.delete();
            rem = 0;
            exp_ovf = 1'b0;
        end else begin
            exp_ovf = f && q.size() == D;
            if (q.size() > 0 && rem <= 1) begin
                cur = q.pop_front();
                rem = 10 * C;
            end else if (rem > 0) rem--;
            if (f && !exp_ovf) q.push_back(b);
        end
        #1;
        ovf_cnt += int'(overflow);
        chk("tx_serial", 32'(tx_serial), 32'(line_exp()));
        chk("tx_busy", 32'(tx_busy), 32'(rem > 0 || q.size() > 0));
        chk("fifo_full", 32'(fifo_full), 32'(q.size() == D));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic drain();
        idle(q.size() * 10 * C + rem + 5);
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h55);
        idle(170);
        step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 8'h0F);
        idle(330);
        ovf_cnt = 0;
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 8'($urandom));
        chk("burst_ovf_pulses", 32'(ovf_cnt), 32'd1);
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'($urandom));
        idle(60);
        step(1'b0, 1'b0, 8'h00);
        idle(40);
        step(1'b1, 1'b1, 8'h3C);
        drain();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom));
        drain();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 8'($urandom));
            idle(int'($urandom_range(0, 40)));
        end
        drain();
        chk("final_idle_line", 32'(tx_serial), 32'd1);
        chk("final_idle_busy", 32'(tx_busy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
